// File: rtl/car_lane_ctrl_if.sv
// Register access port for car_lane_ctrl: a write strobe with address/data
// and a combinational read-back path for the selected register.
interface car_lane_ctrl_if;
  logic        wr_en;
  logic [1:0]  reg_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  modport master (
    output wr_en,
    output reg_addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  reg_addr,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/car_lane_ctrl.sv
// Frame-synchronous motion controller for a single lane-car sprite.
// The car falls down the screen by SPEED pixels per frame, wraps back to the
// top at the bottom edge, and slides horizontally toward its target lane at
// no more than SLIDE pixels per frame. Software controls it through a small
// four-register port.
module car_lane_ctrl #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SPR        = 32,
  parameter int LANE_X0    = 160,
  parameter int LANE_PITCH = 96,
  parameter int SLIDE      = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_tick,
  car_lane_ctrl_if.slave  regs,
  output logic [10:0]     x0,
  output logic [10:0]     y0,
  output logic            active,
  output logic            wrap_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Rightmost origin that keeps the whole sprite on the visible line.
  localparam int X_MAX = H_RES - SPR;

  state_t             state;
  state_t             state_next;
  logic               run_r;
  logic               pause_r;
  logic [3:0]         speed;
  logic [1:0]         lane;
  logic [15:0]        wraps;

  logic               wr_ctrl;
  logic               eff_run;
  logic               eff_pause;
  logic [10:0]        lane_raw;
  logic [10:0]        lane_x;
  logic [11:0]        y_sum;
  logic               wrap_hit;
  logic signed [11:0] dx;
  logic signed [11:0] step;
  logic [10:0]        x_next;
  logic [10:0]        y_next;
  logic               unused_wr_bits;

  // Upper write-data bits have no register behind them.
  assign unused_wr_bits = ^regs.wr_data[15:4];

  // A CTRL write steers the state change on the same edge it is written.
  assign wr_ctrl   = regs.wr_en && (regs.reg_addr == 2'd0);
  assign eff_run   = wr_ctrl ? regs.wr_data[0] : run_r;
  assign eff_pause = wr_ctrl ? regs.wr_data[1] : pause_r;

  // Target lane origin, clamped so a mis-sized parameter set cannot push the sprite off the right edge.
  always_comb begin
    lane_raw = 11'(LANE_X0 + int'(lane) * LANE_PITCH);
    lane_x   = (lane_raw > 11'(X_MAX)) ? 11'(X_MAX) : lane_raw;
  end

  // Next-state selection from the current state and the effective CTRL bits.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (eff_run) state_next = eff_pause ? PAUSE : RUN;
      RUN:     if (!eff_run) state_next = IDLE;
               else if (eff_pause) state_next = PAUSE;
      PAUSE:   if (!eff_run) state_next = IDLE;
               else if (!eff_pause) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Per-frame motion: vertical advance with wrap, horizontal slide clamped to SLIDE.
  always_comb begin
    y_sum    = {1'b0, y0} + {8'd0, speed};
    wrap_hit = (state == RUN) && frame_tick && (state_next != IDLE) &&
               (y_sum >= 12'(V_RES));
    dx       = $signed({1'b0, lane_x}) - $signed({1'b0, x0});
    if (dx > 12'(SLIDE))
      step = 12'(SLIDE);
    else if (dx < -12'(SLIDE))
      step = -12'(SLIDE);
    else
      step = dx;

    x_next = x0;
    y_next = y0;
    if (state_next == IDLE) begin
      x_next = lane_x;
      y_next = 11'(V_RES);
    end else if (state == IDLE) begin
      y_next = 11'd0;
    end else if ((state == RUN) && frame_tick) begin
      y_next = wrap_hit ? 11'd0 : y_sum[10:0];
      x_next = x0 + step[10:0];
    end
  end

  // Configuration registers, wrap counter, state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      run_r      <= 1'b0;
      pause_r    <= 1'b0;
      speed      <= 4'd0;
      lane       <= 2'd0;
      wraps      <= 16'd0;
      x0         <= 11'(LANE_X0);
      y0         <= 11'(V_RES);
      active     <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      if (regs.wr_en) begin
        case (regs.reg_addr)
          2'd0: begin
            run_r   <= regs.wr_data[0];
            pause_r <= regs.wr_data[1];
          end
          2'd1:    speed <= regs.wr_data[3:0];
          2'd2:    lane  <= regs.wr_data[1:0];
          default: ;
        endcase
      end
      if (regs.wr_en && (regs.reg_addr == 2'd3))
        wraps <= 16'd0;
      else if (wrap_hit && (wraps != 16'hFFFF))
        wraps <= wraps + 16'd1;
      state      <= state_next;
      x0         <= x_next;
      y0         <= y_next;
      active     <= (state_next != IDLE);
      wrap_pulse <= wrap_hit;
    end
  end

  // Combinational read-back of the addressed register.
  always_comb begin
    regs.rd_data = 16'd0;
    case (regs.reg_addr)
      2'd0:    regs.rd_data = {14'd0, pause_r, run_r};
      2'd1:    regs.rd_data = {12'd0, speed};
      2'd2:    regs.rd_data = {14'd0, lane};
      default: regs.rd_data = wraps;
    endcase
  end

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Directed testbench for car_lane_ctrl: reset, vertical motion, wrap,
// lane slide and retarget, pause/stop, and same-edge write/tick collisions.
module tb_car_lane_ctrl;

  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic [10:0] x0;
  logic [10:0] y0;
  logic        active;
  logic        wrap_pulse;
  int          vectors;
  int          miscompares;

  car_lane_ctrl_if bus ();

  car_lane_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .regs       (bus.slave),
    .x0         (x0),
    .y0         (y0),
    .active     (active),
    .wrap_pulse (wrap_pulse)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of tick and/or register write, then release the inputs.
  task automatic applyStimulus(input logic tick, input logic we,
                               input logic [1:0] addr, input logic [15:0] data);
    frame_tick   = tick;
    bus.wr_en    = we;
    bus.reg_addr = addr;
    bus.wr_data  = data;
    stepClock();
    frame_tick   = 1'b0;
    bus.wr_en    = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [15:0] data);
    applyStimulus(1'b0, 1'b1, addr, data);
  endtask

  // Back-to-back tick cycles, each counted as its own frame.
  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic readCheck(input string tag, input logic [1:0] addr,
                           input logic [15:0] expected);
    bus.reg_addr = addr;
    #1;
    checkOutput(tag, bus.rd_data, expected);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset_n      = 1'b0;
    frame_tick   = 1'b0;
    bus.wr_en    = 1'b0;
    bus.reg_addr = 2'd0;
    bus.wr_data  = 16'd0;

    // Reset held for two edges.
    stepClock();
    stepClock();
    checkOutput("rst_x0", 16'(x0), 16'd160);
    checkOutput("rst_y0", 16'(y0), 16'd480);
    checkOutput("rst_active", 16'(active), 16'd0);
    checkOutput("rst_wrap", 16'(wrap_pulse), 16'd0);
    readCheck("rst_ctrl", 2'd0, 16'd0);
    readCheck("rst_speed", 2'd1, 16'd0);
    readCheck("rst_lane", 2'd2, 16'd0);
    readCheck("rst_wraps", 2'd3, 16'd0);
    reset_n = 1'b1;
    stepClock();

    // Motion: SPEED 5, start running, ten frames.
    writeReg(2'd1, 16'd5);
    readCheck("rd_speed5", 2'd1, 16'd5);
    writeReg(2'd0, 16'd1);
    checkOutput("start_y0", 16'(y0), 16'd0);
    checkOutput("start_active", 16'(active), 16'd1);
    applyTicks(10);
    checkOutput("motion_y0", 16'(y0), 16'd50);
    checkOutput("motion_x0", 16'(x0), 16'd160);

    // Wrap: restart from the top at SPEED 15.
    writeReg(2'd1, 16'd15);
    writeReg(2'd0, 16'd0);
    checkOutput("park_y0", 16'(y0), 16'd480);
    writeReg(2'd0, 16'd1);
    applyTicks(31);
    checkOutput("prewrap_y0", 16'(y0), 16'd465);
    checkOutput("prewrap_pulse", 16'(wrap_pulse), 16'd0);
    applyTicks(1);
    checkOutput("wrap_y0", 16'(y0), 16'd0);
    checkOutput("wrap_pulse_hi", 16'(wrap_pulse), 16'd1);
    stepClock();
    checkOutput("wrap_pulse_lo", 16'(wrap_pulse), 16'd0);
    readCheck("wraps_1", 2'd3, 16'd1);

    // Slide: SPEED 0 holds y0 while x0 moves toward lane 2.
    writeReg(2'd1, 16'd0);
    writeReg(2'd2, 16'd2);
    checkOutput("lane_nosnap_x0", 16'(x0), 16'd160);
    applyTicks(1);
    checkOutput("slide1_x0", 16'(x0), 16'd164);
    applyTicks(47);
    checkOutput("slide48_x0", 16'(x0), 16'd352);
    checkOutput("speed0_y0", 16'(y0), 16'd0);
    applyTicks(1);
    checkOutput("slide_hold_x0", 16'(x0), 16'd352);
    writeReg(2'd2, 16'd1);
    applyTicks(1);
    checkOutput("retarget_x0", 16'(x0), 16'd348);
    applyTicks(23);
    checkOutput("lane1_x0", 16'(x0), 16'd256);

    // Pause freezes position across ticks; resume continues motion.
    writeReg(2'd1, 16'd2);
    applyTicks(3);
    checkOutput("pre_pause_y0", 16'(y0), 16'd6);
    writeReg(2'd0, 16'd3);
    applyTicks(5);
    checkOutput("pause_y0", 16'(y0), 16'd6);
    checkOutput("pause_x0", 16'(x0), 16'd256);
    checkOutput("pause_active", 16'(active), 16'd1);
    writeReg(2'd0, 16'd1);
    applyTicks(1);
    checkOutput("resume_y0", 16'(y0), 16'd8);
    writeReg(2'd0, 16'd0);
    checkOutput("stop_y0", 16'(y0), 16'd480);
    checkOutput("stop_active", 16'(active), 16'd0);
    checkOutput("stop_x0", 16'(x0), 16'd256);

    // Collision: SPEED write on a tick edge uses the old SPEED for that tick.
    writeReg(2'd0, 16'd1);
    applyTicks(2);
    checkOutput("coll_pre_y0", 16'(y0), 16'd4);
    applyStimulus(1'b1, 1'b1, 2'd1, 16'd9);
    checkOutput("coll_old_speed_y0", 16'(y0), 16'd6);
    applyTicks(1);
    checkOutput("coll_new_speed_y0", 16'(y0), 16'd15);

    // Collision: WRAPS clear on the wrap edge leaves the counter at zero.
    applyTicks(51);
    checkOutput("pre_clr_y0", 16'(y0), 16'd474);
    readCheck("wraps_before_clr", 2'd3, 16'd1);
    applyStimulus(1'b1, 1'b1, 2'd3, 16'd0);
    checkOutput("clr_wrap_y0", 16'(y0), 16'd0);
    checkOutput("clr_wrap_pulse", 16'(wrap_pulse), 16'd1);
    readCheck("wraps_cleared", 2'd3, 16'd0);

    // Reset while running returns to the parked state.
    reset_n = 1'b0;
    stepClock();
    checkOutput("midrst_y0", 16'(y0), 16'd480);
    checkOutput("midrst_x0", 16'(x0), 16'd160);
    checkOutput("midrst_active", 16'(active), 16'd0);
    readCheck("midrst_lane", 2'd2, 16'd0);
    reset_n = 1'b1;
    stepClock();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
